// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: SR/Cause/EPC/PRId,
// handler redirect (Req), eret return address (EPCOut), mfc0/mtc0 access.
// Ports: clk, reset (sync, active-high), M_PC, M_BD, M_ExcCode, M_eret,
//   HWInt, we, addr, wdata -> rdata, Req, EPCOut.
// Option: define CP0_COUNT_EN to add the free-running Count register (reg 9).
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID_VAL = 32'h4255_4141,
   parameter int          HWINT_W  = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        M_PC,
   input  logic               M_BD,
   input  logic [4:0]         M_ExcCode,
   input  logic               M_eret,
   input  logic [HWINT_W-1:0] HWInt,
   input  logic               we,
   input  logic [4:0]         addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               Req,
   output logic [31:0]        EPCOut
);

   localparam logic [4:0] A_SR    = 5'd12;
   localparam logic [4:0] A_CAUSE = 5'd13;
   localparam logic [4:0] A_EPC   = 5'd14;
   localparam logic [4:0] A_PRID  = 5'd15;

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic [5:0]  hw6;
   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_val;
   logic [31:0] cause_val;
   logic        wr_sr;
   logic        wr_epc;

   // IM/IP are fixed 6-bit fields; interrupt lines map onto them LSB first.
   assign hw6 = 6'(HWInt);

   assign int_req = (|(hw6 & sr_im)) & sr_ie & ~sr_exl;
   assign exc_req = (M_ExcCode != 5'd0) & ~sr_exl;
   assign Req     = ~reset & (int_req | exc_req);

   assign wr_sr  = we & (addr == A_SR) & ~Req;
   assign wr_epc = we & (addr == A_EPC) & ~Req;

   // Bypass lets an eret right behind an mtc0 EPC use the new value.
   assign EPCOut = wr_epc ? wdata : epc;

   assign sr_val = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
   assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0,
                       cause_exc, 2'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= hw6;
         if (Req) begin
            sr_exl    <= 1'b1;
            cause_bd  <= M_BD;
            cause_exc <= int_req ? 5'd0 : M_ExcCode;
            epc       <= M_BD ? (M_PC - 32'd4) : M_PC;
         end else begin
            if (wr_sr) begin
               sr_im  <= wdata[15:10];
               sr_exl <= wdata[1];
               sr_ie  <= wdata[0];
            end
            if (wr_epc)
               epc <= wdata;
            // eret wins over a same-cycle EXL write.
            if (M_eret)
               sr_exl <= 1'b0;
         end
      end
   end

`ifdef CP0_COUNT_EN
   logic [31:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (we && addr == 5'd9 && !Req)
         count <= wdata;
      else
         count <= count + 32'd1;
   end
`endif

   always_comb begin
      rdata = '0;
      unique case (addr)
         A_SR:    rdata = sr_val;
         A_CAUSE: rdata = cause_val;
         A_EPC:   rdata = epc;
         A_PRID:  rdata = PRID_VAL;
`ifdef CP0_COUNT_EN
         5'd9:    rdata = count;
`endif
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] M_PC;
   logic        M_BD;
   logic [4:0]  M_ExcCode;
   logic        M_eret;
   logic [5:0]  HWInt;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        Req;
   logic [31:0] EPCOut;

   int checks;
   int failures;

   cp0_exc_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .M_PC      (M_PC),
      .M_BD      (M_BD),
      .M_ExcCode (M_ExcCode),
      .M_eret    (M_eret),
      .HWInt     (HWInt),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .Req       (Req),
      .EPCOut    (EPCOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag,
                     input logic [4:0] a,
                     input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      M_PC      = '0;
      M_BD      = 1'b0;
      M_ExcCode = 5'd4;
      M_eret    = 1'b0;
      HWInt     = '0;
      we        = 1'b0;
      addr      = '0;
      wdata     = '0;

      step();
      step();
      chk("req_in_reset", {31'b0, Req}, 32'd0);
      chk("epcout_reset", EPCOut, 32'd0);
      M_ExcCode = 5'd0;
      reset = 1'b0;
      step();

      rd("rst_sr", 5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc", 5'd14, 32'h0);
      rd("rst_prid", 5'd15, 32'h4255_4141);
      rd("rst_other", 5'd3, 32'h0);
      chk("rst_req", {31'b0, Req}, 32'd0);

      // plain exception
      M_ExcCode = 5'd4;
      M_PC = 32'h3008;
      #1;
      chk("exc_req", {31'b0, Req}, 32'd1);
      step();
      chk("exc_nested_req", {31'b0, Req}, 32'd0);
      M_ExcCode = 5'd0;
      rd("exc_epc", 5'd14, 32'h3008);
      rd("exc_cause", 5'd13, 32'h10);
      rd("exc_sr", 5'd12, 32'h2);
      chk("exc_epcout", EPCOut, 32'h3008);

      // nested exception must not disturb EPC
      M_ExcCode = 5'd7;
      M_PC = 32'h5000;
      step();
      M_ExcCode = 5'd0;
      rd("nest_epc", 5'd14, 32'h3008);

      M_eret = 1'b1;
      step();
      M_eret = 1'b0;
      rd("eret1_sr", 5'd12, 32'h0);

      // delay slot exception
      M_ExcCode = 5'd10;
      M_PC = 32'h3010;
      M_BD = 1'b1;
      #1;
      chk("bd_req", {31'b0, Req}, 32'd1);
      step();
      M_ExcCode = 5'd0;
      M_BD = 1'b0;
      rd("bd_epc", 5'd14, 32'h300C);
      rd("bd_cause", 5'd13, 32'h8000_0028);
      M_eret = 1'b1;
      #1;
      chk("bd_epcout", EPCOut, 32'h300C);
      step();
      M_eret = 1'b0;
      rd("bd_eret_sr", 5'd12, 32'h0);

      // interrupt beats exception
      we = 1'b1;
      addr = 5'd12;
      wdata = 32'h0000_0401;
      step();
      we = 1'b0;
      rd("int_sr_wr", 5'd12, 32'h401);
      HWInt = 6'b000001;
      M_ExcCode = 5'd12;
      M_PC = 32'h3020;
      #1;
      chk("int_req", {31'b0, Req}, 32'd1);
      step();
      M_ExcCode = 5'd0;
      rd("int_cause", 5'd13, 32'h400);
      rd("int_epc", 5'd14, 32'h3020);
      rd("int_sr", 5'd12, 32'h403);
      chk("int_exl_req", {31'b0, Req}, 32'd0);

      // mtc0 SR with EXL set plus eret: EXL ends cleared
      we = 1'b1;
      addr = 5'd12;
      wdata = 32'h0000_0402;
      M_eret = 1'b1;
      step();
      we = 1'b0;
      M_eret = 1'b0;
      rd("sr_eret_mix", 5'd12, 32'h400);
      chk("ie0_req", {31'b0, Req}, 32'd0);
      rd("ie0_ip", 5'd13, 32'h400);
      HWInt = 6'b100000;
      step();
      rd("ip_track", 5'd13, 32'h8000);
      HWInt = 6'b000000;
      step();
      rd("ip_clear", 5'd13, 32'h0);

      // mtc0 Cause and PRId ignored
      we = 1'b1;
      addr = 5'd13;
      wdata = 32'hFFFF_FFFF;
      step();
      addr = 5'd15;
      step();
      we = 1'b0;
      rd("cause_ro", 5'd13, 32'h0);
      rd("prid_ro", 5'd15, 32'h4255_4141);

      // EPC bypass
      we = 1'b1;
      addr = 5'd14;
      wdata = 32'h3400;
      #1;
      chk("byp_epcout", EPCOut, 32'h3400);
      chk("byp_no_rd", rdata, 32'h3020);
      step();
      we = 1'b0;
      rd("byp_epc", 5'd14, 32'h3400);

      // bypass and write dropped under Req
      we = 1'b1;
      addr = 5'd14;
      wdata = 32'h3600;
      M_ExcCode = 5'd4;
      M_PC = 32'h3500;
      #1;
      chk("drop_req", {31'b0, Req}, 32'd1);
      chk("drop_epcout", EPCOut, 32'h3400);
      step();
      we = 1'b0;
      M_ExcCode = 5'd0;
      rd("drop_epc", 5'd14, 32'h3500);

      // Count register
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd("rst2_epc", 5'd14, 32'h0);
      repeat (10) step();
`ifdef CP0_COUNT_EN
      rd("cnt_10", 5'd9, 32'd10);
      we = 1'b1;
      addr = 5'd9;
      wdata = 32'hFFFF_FFFF;
      step();
      we = 1'b0;
      rd("cnt_load", 5'd9, 32'hFFFF_FFFF);
      step();
      rd("cnt_wrap", 5'd9, 32'h0);
      step();
      rd("cnt_1", 5'd9, 32'd1);
`else
      rd("cnt_none", 5'd9, 32'h0);
      we = 1'b1;
      addr = 5'd9;
      wdata = 32'h1234_5678;
      step();
      we = 1'b0;
      rd("cnt_none_wr", 5'd9, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
